serial_frame_serializer: RTL

Parallel-to-serial front end for the serial bit-stream pattern detectors. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on a registered serial line `x` with a qualifying `x_valid`. A one-word holding buffer lets consecutive words stream with no idle cycle between frames. An optional even-parity bit can be appended to each frame.

---
 rtl/serializer_pkg.sv | 26 ++
 rtl/ser_hold_reg.sv | 36 +++
 rtl/serial_frame_serializer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/serializer_pkg.sv
// Shared types and helpers for the serial frame serializer.
// Optional feature macro: SERIALIZER_PARITY_EN (adds the PARITY state).
package serializer_pkg;

  // Serial line level while no frame bit is being driven.
  localparam logic SER_IDLE_LEVEL = 1'b0;

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;
`else
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;
`endif

  // Bit-counter width: must hold WIDTH-1 (at least one bit).
  function automatic int unsigned ser_cnt_w(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry holding buffer for the serializer.
// Ports:
//   clk, reset   - clock, async active-low reset (buffer empties)
//   load         - write load_word into the buffer (marks it full)
//   load_word    - word to store
//   drain        - buffer contents consumed this cycle (marks it empty)
//   full         - buffer holds a word
//   word         - stored word
// A simultaneous load and drain leaves the buffer full with the new word.
module ser_hold_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,
  input  logic             drain,
  output logic             full,
  output logic [WIDTH-1:0] word
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full <= 1'b0;
      word <= '0;
    end else begin
      if (load) begin
        full <= 1'b1;
        word <= load_word;
      end else if (drain) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_frame_serializer.sv
// Parallel-to-serial frame serializer, MSB first, one bit per clock.
// Optional feature macro: SERIALIZER_PARITY_EN appends an even-parity bit.
// Ports:
//   clk, reset      - clock, async active-low reset
//   din, din_valid  - parallel word and its valid
//   din_ready       - holding buffer empty (combinational)
//   x, x_valid      - registered serial bit and qualifier
//   frame_done      - pulse during the final bit of each frame
//   busy            - shifter active or holding buffer full
module serial_frame_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter logic        IDLE_LEVEL = SER_IDLE_LEVEL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned SER_CNT_W = ser_cnt_w(WIDTH);

  ser_state_t           state_q, state_d;
  logic [WIDTH-1:0]     sh_q, sh_d;
  logic [SER_CNT_W-1:0] cnt_q, cnt_d;
  logic                 x_d, x_valid_d, frame_done_d, busy_d;

  logic                 hold_full, hold_full_d;
  logic [WIDTH-1:0]     hold_word;
  logic                 hold_load, hold_drain;

  logic                 accept_c;
  logic                 end_c;
  logic                 load_en;
  logic [WIDTH-1:0]     load_word;

`ifdef SERIALIZER_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign din_ready = !hold_full;
  assign accept_c  = din_valid && din_ready;

  ser_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .load      (hold_load),
    .load_word (din),
    .drain     (hold_drain),
    .full      (hold_full),
    .word      (hold_word)
  );

  // Next-state, shifter and output logic.
  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    cnt_d        = cnt_q;
    x_d          = x;
    x_valid_d    = x_valid;
    frame_done_d = 1'b0;
    hold_load    = 1'b0;
    hold_drain   = 1'b0;
    load_en      = 1'b0;
    load_word    = din;
    end_c        = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    par_d        = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          load_en = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
`ifdef SERIALIZER_PARITY_EN
          state_d      = PARITY;
          x_d          = par_q;
          frame_done_d = 1'b1;
          hold_load    = accept_c;
`else
          end_c = 1'b1;
`endif
        end else begin
          x_d       = sh_q[WIDTH-1];
          sh_d      = sh_q << 1;
          cnt_d     = cnt_q - SER_CNT_W'(1);
`ifndef SERIALIZER_PARITY_EN
          frame_done_d = (cnt_q == SER_CNT_W'(1));
`endif
          hold_load = accept_c;
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        end_c = 1'b1;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    // End of frame: buffered word first, then a same-cycle transfer, else idle.
    if (end_c) begin
      if (hold_full) begin
        load_en    = 1'b1;
        load_word  = hold_word;
        hold_drain = 1'b1;
      end else if (accept_c) begin
        load_en = 1'b1;
      end else begin
        state_d   = IDLE;
        x_d       = IDLE_LEVEL;
        x_valid_d = 1'b0;
      end
    end

    // Shifter load: MSB goes straight onto the line, rest waits in sh.
    if (load_en) begin
      state_d   = SHIFT;
      x_d       = load_word[WIDTH-1];
      x_valid_d = 1'b1;
      sh_d      = {load_word[WIDTH-2:0], 1'b0};
      cnt_d     = SER_CNT_W'(WIDTH - 1);
`ifdef SERIALIZER_PARITY_EN
      par_d     = ^load_word;
`endif
    end

    hold_full_d = (hold_full && !hold_drain) || hold_load;
    busy_d      = (state_d != IDLE) || hold_full_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      cnt_q      <= '0;
      x          <= IDLE_LEVEL;
      x_valid    <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      x          <= x_d;
      x_valid    <= x_valid_d;
      frame_done <= frame_done_d;
      busy       <= busy_d;
    end
  end

`ifdef SERIALIZER_PARITY_EN
  // Parity of the word currently in the shifter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

endmodule
